tetris_field_buffer: RTL and testbench

Playfield storage between the Nios row PIOs and the VGA pixel generator. It latches 30-bit row words (10 cells × 3-bit colour) from the row PIO's `out_port` under a commit strobe into a 20-row register array. It also answers per-pixel colour lookups from the VGA scanner with fixed 2-cycle latency. A sequenced clear engine wipes the field between games.

---
 rtl/tetris_pkg.sv | 37 +++
 rtl/tetris_pix_lookup.sv | 77 +++++++
 rtl/tetris_field_buffer.sv | 183 ++++++++++++++++++
 tb/tb_tetris_field_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared constants, colour codes and FSM states for the playfield buffer
package tetris_pkg;

    localparam int FIELD_COLS = 10;
    localparam int CELL_BITS  = 3;
    localparam int ROW_BITS   = 30;

    typedef enum logic [CELL_BITS-1:0] {
        CLR_EMPTY  = 3'd0,
        CLR_CYAN   = 3'd1,
        CLR_BLUE   = 3'd2,
        CLR_ORANGE = 3'd3,
        CLR_YELLOW = 3'd4,
        CLR_GREEN  = 3'd5,
        CLR_PURPLE = 3'd6,
        CLR_RED    = 3'd7
    } color_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // Pick cell `col` out of a packed row word; out-of-range columns read as empty.
    function automatic logic [CELL_BITS-1:0] cell_of(input logic [ROW_BITS-1:0] word,
                                                     input logic [3:0]          col);
        logic [CELL_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < FIELD_COLS; i++) begin
            if (col == 4'(i)) begin
                c = word[CELL_BITS*i +: CELL_BITS];
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tetris_pix_lookup.sv
// rtl/tetris_pix_lookup.sv - two-stage pixel coordinate to cell colour pipeline
module tetris_pix_lookup
    import tetris_pkg::*;
#(
    parameter int ROWS       = 20,
    parameter int FIELD_X0   = 240,
    parameter int FIELD_Y0   = 80,
    parameter int CELL_SHIFT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pix_valid,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    output logic [4:0]          rd_addr,
    input  logic [ROW_BITS-1:0] rd_data,
    output logic [2:0]          pix_color,
    output logic                pix_in_field,
    output logic                pix_color_valid
);

    localparam logic [10:0] X0     = 11'(FIELD_X0);
    localparam logic [10:0] Y0     = 11'(FIELD_Y0);
    localparam logic [10:0] WIDTH  = 11'(FIELD_COLS << CELL_SHIFT);
    localparam logic [10:0] HEIGHT = 11'(ROWS << CELL_SHIFT);

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_field_c;
    logic [3:0]  col_c;
    logic [4:0]  row_c;

    logic [3:0]  col_q;
    logic [4:0]  row_q;
    logic        in_field_q;
    logic        valid_q;

    // Field-relative offsets; negative offsets wrap to large unsigned values and fail the range test.
    always_comb begin
        dx         = {1'b0, pix_x} - X0;
        dy         = {1'b0, pix_y} - Y0;
        in_field_c = (dx < WIDTH) && (dy < HEIGHT);
        col_c      = in_field_c ? 4'(dx >> CELL_SHIFT) : 4'd0;
        row_c      = in_field_c ? 5'(dy >> CELL_SHIFT) : 5'd0;
    end

    // Stage 1: register the cell address so stage 2 reads the array with a clean address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            in_field_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            col_q      <= col_c;
            row_q      <= row_c;
            in_field_q <= in_field_c;
            valid_q    <= pix_valid;
        end
    end

    assign rd_addr = row_q;

    // Stage 2: select the cell out of the row word; anything outside the field is colour 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_color       <= '0;
            pix_in_field    <= 1'b0;
            pix_color_valid <= 1'b0;
        end else begin
            pix_color       <= in_field_q ? cell_of(rd_data, col_q) : 3'd0;
            pix_in_field    <= in_field_q;
            pix_color_valid <= valid_q;
        end
    end

endmodule

// File: rtl/tetris_field_buffer.sv
// rtl/tetris_field_buffer.sv - playfield row array with commit, clear engine and pixel lookup
module tetris_field_buffer
    import tetris_pkg::*;
#(
    parameter int ROWS       = 20,
    parameter int FIELD_X0   = 240,
    parameter int FIELD_Y0   = 80,
    parameter int CELL_SHIFT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ROW_BITS-1:0] row_data,
    input  logic [4:0]          row_index,
    input  logic                commit_in,
    input  logic                clear_in,
    input  logic                pix_valid,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    output logic [2:0]          pix_color,
    output logic                pix_in_field,
    output logic                pix_color_valid,
    output logic                busy,
    output logic                err_index
);

    localparam logic [4:0] ROWS_L   = 5'(ROWS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [ROW_BITS-1:0] field_mem [ROWS];

    logic                commit_q;
    logic                clear_q;
    logic                commit_edge;
    logic                clear_edge;

    state_t              state;
    state_t              state_n;
    logic [4:0]          clr_ptr;
    logic [4:0]          clr_ptr_n;
    logic                pend;
    logic                pend_n;
    logic [ROW_BITS-1:0] pend_data;
    logic [ROW_BITS-1:0] pend_data_n;
    logic [4:0]          pend_idx;
    logic [4:0]          pend_idx_n;
    logic                err_n;

    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [ROW_BITS-1:0] wr_data;

    logic [4:0]          rd_addr;
    logic [ROW_BITS-1:0] rd_data;

    assign commit_edge = commit_in & ~commit_q;
    assign clear_edge  = clear_in & ~clear_q;
    assign busy        = (state == ST_CLEAR);

    // Edge-detect registers; zero at reset so a level held high through reset counts as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            commit_q <= commit_in;
            clear_q  <= clear_in;
        end
    end

    // Next-state and single write-port decode: clear rows, drain the pending slot, or take a commit.
    always_comb begin
        state_n     = state;
        clr_ptr_n   = clr_ptr;
        pend_n      = pend;
        pend_data_n = pend_data;
        pend_idx_n  = pend_idx;
        err_n       = err_index;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        case (state)
            ST_IDLE: begin
                if (pend) begin
                    if (pend_idx < ROWS_L) begin
                        wr_en   = 1'b1;
                        wr_addr = pend_idx;
                        wr_data = pend_data;
                    end else begin
                        err_n = 1'b1;
                    end
                    // A commit colliding with the drain waits one cycle in the same slot.
                    if (commit_edge) begin
                        pend_data_n = row_data;
                        pend_idx_n  = row_index;
                    end else begin
                        pend_n = 1'b0;
                    end
                end else if (commit_edge) begin
                    if (row_index < ROWS_L) begin
                        wr_en   = 1'b1;
                        wr_addr = row_index;
                        wr_data = row_data;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                if (clear_edge) begin
                    state_n   = ST_CLEAR;
                    clr_ptr_n = '0;
                    err_n     = 1'b0;
                end
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr;
                wr_data = '0;
                if (clr_ptr == LAST_ROW) begin
                    state_n   = ST_IDLE;
                    clr_ptr_n = '0;
                end else begin
                    clr_ptr_n = clr_ptr + 5'd1;
                end
                if (commit_edge) begin
                    pend_n      = 1'b1;
                    pend_data_n = row_data;
                    pend_idx_n  = row_index;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Control state: FSM, clear pointer, pending slot and sticky index error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            clr_ptr   <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
            pend_idx  <= '0;
            err_index <= 1'b0;
        end else begin
            state     <= state_n;
            clr_ptr   <= clr_ptr_n;
            pend      <= pend_n;
            pend_data <= pend_data_n;
            pend_idx  <= pend_idx_n;
            err_index <= err_n;
        end
    end

    // Row array: one write per cycle from the decode above.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) begin
                field_mem[r] <= '0;
            end
        end else if (wr_en) begin
            field_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (rd_addr < ROWS_L) ? field_mem[rd_addr] : '0;

    tetris_pix_lookup #(
        .ROWS       (ROWS),
        .FIELD_X0   (FIELD_X0),
        .FIELD_Y0   (FIELD_Y0),
        .CELL_SHIFT (CELL_SHIFT)
    ) u_lookup (
        .clk             (clk),
        .reset_n         (reset_n),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .pix_color       (pix_color),
        .pix_in_field    (pix_in_field),
        .pix_color_valid (pix_color_valid)
    );

endmodule

// File: tb/tb_tetris_field_buffer.sv
// tb/tb_tetris_field_buffer.sv - directed self-checking bench for tetris_field_buffer
module tb_tetris_field_buffer;

    localparam logic [29:0] ONES = 30'h3FFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] row_data;
    logic [4:0]  row_index;
    logic        commit_in;
    logic        clear_in;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [2:0]  pix_color;
    logic        pix_in_field;
    logic        pix_color_valid;
    logic        busy;
    logic        err_index;

    int n_vec  = 0;
    int n_miss = 0;
    int cnt;

    tetris_field_buffer #(
        .ROWS       (20),
        .FIELD_X0   (240),
        .FIELD_Y0   (80),
        .CELL_SHIFT (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .row_data        (row_data),
        .row_index       (row_index),
        .commit_in       (commit_in),
        .clear_in        (clear_in),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_color       (pix_color),
        .pix_in_field    (pix_in_field),
        .pix_color_valid (pix_color_valid),
        .busy            (busy),
        .err_index       (err_index)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic commit(input logic [4:0] idx, input logic [29:0] data);
        row_index = idx;
        row_data  = data;
        commit_in = 1'b1;
        @(negedge clk);
        commit_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
    endtask

    task automatic lookup(input string tag, input int x, input int y,
                          input logic [2:0] exp_c, input logic exp_in);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        @(negedge clk);
        pix_valid = 1'b0;
        check_vec({tag, ".early"}, 32'(pix_color_valid), 32'd0);
        @(negedge clk);
        check_vec({tag, ".valid"}, 32'(pix_color_valid), 32'd1);
        check_vec({tag, ".color"}, 32'(pix_color), 32'(exp_c));
        check_vec({tag, ".infld"}, 32'(pix_in_field), 32'(exp_in));
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        row_data  = '0;
        row_index = '0;
        commit_in = 1'b0;
        clear_in  = 1'b0;
        pix_valid = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        repeat (3) @(negedge clk);
        check_vec("rst.busy", 32'(busy), 32'd0);
        check_vec("rst.err", 32'(err_index), 32'd0);
        check_vec("rst.color", 32'(pix_color), 32'd0);
        check_vec("rst.infld", 32'(pix_in_field), 32'd0);
        check_vec("rst.cvalid", 32'(pix_color_valid), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        lookup("rst.lk", 240, 80, 3'd0, 1'b1);

        // Basic commit and lookup
        commit(5'd19, ONES);
        lookup("basic", 240, 384, 3'd7, 1'b1);

        // Cell packing and field boundaries
        commit(5'd0, 30'h2800_0000);
        lookup("pack.c9", 399, 80, 3'd5, 1'b1);
        lookup("pack.xr", 400, 80, 3'd0, 1'b0);
        lookup("pack.c8", 383, 80, 3'd0, 1'b1);
        lookup("pack.xl", 239, 80, 3'd0, 1'b0);
        lookup("pack.yt", 240, 79, 3'd0, 1'b0);
        lookup("pack.yb", 240, 399, 3'd7, 1'b1);
        lookup("pack.yo", 240, 400, 3'd0, 1'b0);

        // Out-of-range index, then clear
        commit(5'd20, 30'h155);
        check_vec("oor.err", 32'(err_index), 32'd1);
        lookup("oor.r19", 240, 384, 3'd7, 1'b1);
        lookup("oor.r0", 399, 80, 3'd5, 1'b1);
        pulse_clear();
        check_vec("clr.busy", 32'(busy), 32'd1);
        check_vec("clr.err", 32'(err_index), 32'd0);
        wait_idle(cnt);
        check_vec("clr.len", 32'(cnt), 32'd20);
        lookup("clr.r19", 240, 384, 3'd0, 1'b1);
        lookup("clr.r0", 399, 80, 3'd0, 1'b1);

        // Commit during CLEAR at clear cycle 10
        for (int r = 0; r < 20; r++) commit(5'(r), ONES);
        lookup("fill.r10", 320, 240, 3'd7, 1'b1);
        pulse_clear();
        repeat (10) @(negedge clk);
        commit(5'd3, 30'h1);
        wait_idle(cnt);
        check_vec("pend.len", 32'(cnt), 32'd8);
        lookup("pend.r3c0", 240, 128, 3'd1, 1'b1);
        lookup("pend.r3c1", 256, 128, 3'd0, 1'b1);
        lookup("pend.r3c9", 384, 128, 3'd0, 1'b1);
        lookup("pend.r0", 240, 80, 3'd0, 1'b1);
        lookup("pend.r19", 384, 384, 3'd0, 1'b1);

        // Last-wins pending slot
        pulse_clear();
        commit(5'd2, 30'h2);
        commit(5'd4, 30'h4);
        wait_idle(cnt);
        check_vec("lw.len", 32'(cnt), 32'd16);
        lookup("lw.r2", 240, 112, 3'd0, 1'b1);
        lookup("lw.r4", 240, 144, 3'd4, 1'b1);

        // Commit and clear edges in the same cycle: commit is wiped
        row_index = 5'd5;
        row_data  = ONES;
        commit_in = 1'b1;
        clear_in  = 1'b1;
        @(negedge clk);
        commit_in = 1'b0;
        clear_in  = 1'b0;
        check_vec("both.busy", 32'(busy), 32'd1);
        wait_idle(cnt);
        check_vec("both.len", 32'(cnt), 32'd20);
        @(negedge clk);
        lookup("both.r5", 240, 160, 3'd0, 1'b1);

        // Reset in the middle of a clear
        commit(5'd7, ONES);
        lookup("mid.pre", 240, 192, 3'd7, 1'b1);
        pulse_clear();
        repeat (3) @(negedge clk);
        commit(5'd9, ONES);
        check_vec("mid.busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_vec("mid.busy", 32'(busy), 32'd0);
        check_vec("mid.err", 32'(err_index), 32'd0);
        check_vec("mid.color", 32'(pix_color), 32'd0);
        check_vec("mid.infld", 32'(pix_in_field), 32'd0);
        check_vec("mid.cvalid", 32'(pix_color_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_vec("mid.busy_post", 32'(busy), 32'd0);
        lookup("mid.r7", 240, 192, 3'd0, 1'b1);
        lookup("mid.r9", 240, 224, 3'd0, 1'b1);
        lookup("mid.r4", 240, 144, 3'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
